// File: rtl/ibex_rf_wb_arbiter_if.sv
// Writeback arbiter bus: the EX request, the LSU response and load issue, the register-file
// write port, the ID operand addresses and the status outputs.
interface ibex_rf_wb_arbiter_if #(
    parameter int DataWidth = 32
);
    logic                 ex_valid_i;
    logic                 ex_ready_o;
    logic [4:0]           ex_waddr_i;
    logic [DataWidth-1:0] ex_wdata_i;

    logic                 lsu_valid_i;
    logic [4:0]           lsu_waddr_i;
    logic [DataWidth-1:0] lsu_wdata_i;
    logic                 lsu_issue_i;
    logic [4:0]           lsu_issue_addr_i;

    logic                 we_a_o;
    logic [4:0]           waddr_a_o;
    logic [DataWidth-1:0] wdata_a_o;

    logic [4:0]           raddr_a_i;
    logic [4:0]           raddr_b_i;
    logic                 hazard_o;
    logic [2:0]           fifo_count_o;

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i, lsu_issue_i, lsu_issue_addr_i,
        input  raddr_a_i, raddr_b_i,
        output ex_ready_o, we_a_o, waddr_a_o, wdata_a_o, hazard_o, fifo_count_o
    );

    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i, lsu_issue_i, lsu_issue_addr_i,
        output raddr_a_i, raddr_b_i,
        input  ex_ready_o, we_a_o, waddr_a_o, wdata_a_o, hazard_o, fifo_count_o
    );
endinterface

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file writeback arbiter: LSU responses win, ALU writes are buffered in order behind them.
// Define IBEX_RF_WB_SCOREBOARD_EN to add the pending-load busy scoreboard that drives hazard_o.
module ibex_rf_wb_arbiter #(
    parameter int DataWidth = 32,
    parameter int FifoDepth = 2
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    ibex_rf_wb_arbiter_if.slave  bus
);
    localparam logic [2:0] Depth   = 3'(FifoDepth);
    localparam logic [1:0] LastPtr = 2'(FifoDepth - 1);

    // Storage is sized for the largest legal depth; entries past FifoDepth are never addressed.
    logic [4:0]           fifo_waddr_q [4];
    logic [DataWidth-1:0] fifo_wdata_q [4];
    logic [1:0]           wptr_q, rptr_q;
    logic [2:0]           count_q, count_d;

    logic                 ex_ready, ex_fire, fifo_empty, push, pop;
    logic                 sel_valid;
    logic [4:0]           sel_addr;
    logic [DataWidth-1:0] sel_data;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LastPtr) ? 2'd0 : p + 2'd1;
    endfunction

    assign ex_ready   = (count_q < Depth);
    assign ex_fire    = bus.ex_valid_i & ex_ready;
    assign fifo_empty = (count_q == 3'd0);
    assign push       = ex_fire & (bus.lsu_valid_i | ~fifo_empty);
    assign pop        = ~bus.lsu_valid_i & ~fifo_empty;

    assign bus.ex_ready_o   = ex_ready;
    assign bus.fifo_count_o = count_q;

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = bus.lsu_waddr_i;
        sel_data  = bus.lsu_wdata_i;
        if (bus.lsu_valid_i) begin
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_addr  = fifo_waddr_q[rptr_q];
            sel_data  = fifo_wdata_q[rptr_q];
        end else if (ex_fire) begin
            sel_valid = 1'b1;
            sel_addr  = bus.ex_waddr_i;
            sel_data  = bus.ex_wdata_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 3'd0;
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_waddr_q[wptr_q] <= bus.ex_waddr_i;
            fifo_wdata_q[wptr_q] <= bus.ex_wdata_i;
        end
    end

    // Writes to x0 still move the address/data registers so the port reflects the last grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.we_a_o    <= 1'b0;
            bus.waddr_a_o <= 5'd0;
            bus.wdata_a_o <= '0;
        end else begin
            bus.we_a_o <= sel_valid & (sel_addr != 5'd0);
            if (sel_valid) begin
                bus.waddr_a_o <= sel_addr;
                bus.wdata_a_o <= sel_data;
            end
        end
    end

`ifdef IBEX_RF_WB_SCOREBOARD_EN
    logic [31:1] busy_q, busy_d;
    logic [31:0] busy_rd;

    // A new issue to a register outranks the completion of an older load to it.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < 32; i++) begin
            if (bus.lsu_valid_i && bus.lsu_waddr_i == 5'(i))           busy_d[i] = 1'b0;
            if (bus.lsu_issue_i && bus.lsu_issue_addr_i == 5'(i))      busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy_rd      = {busy_q, 1'b0};
    assign bus.hazard_o = busy_rd[bus.raddr_a_i] | busy_rd[bus.raddr_b_i];
`else
    logic unused_scoreboard_in;
    assign unused_scoreboard_in = ^{bus.lsu_issue_i, bus.lsu_issue_addr_i, bus.raddr_a_i, bus.raddr_b_i};
    assign bus.hazard_o         = 1'b0;
`endif

endmodule

// File: doc/ibex_rf_wb_arbiter.md
IBEX_RF_WB_ARBITER -- requirements
Module: ibex_rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register data width.
REQ-002 SHALL have parameter FifoDepth, default 2, EX-side buffer entries, legal values 1..4.
REQ-003 SHALL have clk_i  input  1  clock, rising edge.
REQ-004 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ex_valid_i / ex_ready_o / ex_waddr_i / ex_wdata_i  in/out/in/in  1/1/5/DataWidth  ALU writeback request, valid/ready handshake.
REQ-006 SHALL have lsu_valid_i / lsu_waddr_i / lsu_wdata_i  input  1/5/DataWidth  load response writeback, no back-pressure.
REQ-007 SHALL have lsu_issue_i / lsu_issue_addr_i  input  1/5  load issued with destination register.
REQ-008 SHALL have we_a_o / waddr_a_o / wdata_a_o  output  1/5/DataWidth  register file write port, registered.
REQ-009 SHALL have raddr_a_i / raddr_b_i  input  5/5  ID-stage operand addresses.
REQ-010 SHALL have hazard_o  output  1  operand reads a register with a pending load.
REQ-011 SHALL have fifo_count_o  output  3  current EX buffer occupancy.

Function
REQ-012 SHALL register all write-port outputs; a selected request appears on we_a_o exactly one cycle after selection.
REQ-013 SHALL select per cycle in fixed priority: LSU request, then FIFO head, then direct EX request.
REQ-014 SHALL accept an EX request (ex_valid_i & ex_ready_o) into the FIFO when lsu_valid_i is high or the FIFO is non-empty; otherwise it is written directly.
REQ-015 SHALL drive ex_ready_o = (fifo_count_o < FifoDepth), from registered count only; a same-cycle pop gives no extra credit.
REQ-016 SHALL preserve EX write order; FIFO pointers wrap modulo FifoDepth; push and pop in the same cycle leave count unchanged.
REQ-017 SHALL accept writes to address 0 but drive we_a_o low for them; waddr_a_o/wdata_a_o still update.
REQ-018 SHALL hold we_a_o low in any cycle with no selected request; waddr_a_o/wdata_a_o hold their last values.
REQ-019 SHALL never lose an LSU request; lsu_valid_i is honoured every cycle it is high.

Reset
REQ-020 SHALL reset we_a_o=0, waddr_a_o=0, wdata_a_o=0, fifo_count_o=0, FIFO pointers=0, all busy bits=0, hazard_o=0.
REQ-021 SHALL discard all buffered EX entries on reset mid-operation; ex_ready_o=1 in the first cycle after reset release.

Configuration
REQ-022 SHALL, with macro IBEX_RF_WB_SCOREBOARD_EN defined, keep 31 busy flops (x1..x31): set on lsu_issue_i for a non-zero lsu_issue_addr_i, cleared when lsu_valid_i is selected with a matching lsu_waddr_i; same-cycle set and clear of one register leaves it set.
REQ-023 SHALL, with IBEX_RF_WB_SCOREBOARD_EN defined, drive hazard_o = busy[raddr_a_i] | busy[raddr_b_i] combinationally, with busy[0] reading 0.
REQ-024 SHALL, without IBEX_RF_WB_SCOREBOARD_EN, tie hazard_o to 0, instantiate no busy flops, and treat lsu_issue_i, lsu_issue_addr_i, raddr_a_i and raddr_b_i as unused.

Verification
REQ-025 SHALL cover: EX only, ex_waddr=5, wdata=0x11 -> next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0x11, fifo_count_o=0.
REQ-026 SHALL cover: same-cycle LSU x3=0xAA and EX x4=0xBB -> cycle+1 writes x3; cycle+2 writes x4; fifo_count_o goes 1 then 0.
REQ-027 SHALL cover: lsu_valid_i held high for 4 cycles with EX streaming, FifoDepth=2 -> ex_ready_o=0 after 2 accepts; EX writes then drain in order with no loss.
REQ-028 SHALL cover: EX write to x0 value 0xFF -> accepted, we_a_o stays 0.
REQ-029 SHALL cover: with the macro defined, issue load to x7 then raddr_a_i=7 -> hazard_o=1 until the cycle lsu_valid_i with waddr 7 is selected, then hazard_o=0.
REQ-030 SHALL cover: rst_ni asserted with 2 FIFO entries pending -> all outputs 0, no buffered write appears after reset release.
